triagem_arbiter: RTL and testbench

Round-robin controller that shares one deposit classifier (sensor pair `cqs`/`cqn`) between two intake stations. It grants the classifier to one requester at a time and waits, with a timeout, for a classification. It then credits the granted station or flags a discard, and keeps a saturating credit count per station that downstream logic can spend. It sits above the per-station sorting FSMs and owns the credit counters those FSMs previously pulsed.

---
 rtl/triagem_arbiter.sv | 119 +++++++++++
 tb/tb_triagem_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/triagem_arbiter.sv
// triagem_arbiter: round-robin owner of the shared deposit classifier with per-station saturating credits
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req0, req1          level-held deposit requests, dropped once done is seen
//   spend0, spend1      one-cycle pulses that consume one credit from a station
//   cqs, cqn            classifier verdict: valid item / invalid item
//   grant0, grant1      one-hot classifier ownership (GRANT and CLASSIFY only)
//   done                transaction finished, owner must drop its request
//   accept, discard     one-cycle verdict pulses
//   timeout_err         one-cycle pulse when the classifier never resolved
//   credit0, credit1    saturating per-station credit counts
module triagem_arbiter #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic             spend0,
   input  logic             spend1,
   input  logic             cqs,
   input  logic             cqn,
   output logic             grant0,
   output logic             grant1,
   output logic             done,
   output logic             accept,
   output logic             discard,
   output logic             timeout_err,
   output logic [CNT_W-1:0] credit0,
   output logic [CNT_W-1:0] credit1
);
   typedef enum logic [1:0] {IDLE, GRANT, CLASSIFY, RELEASE} state_t;
   state_t state, state_n;
   logic owner, owner_n, last, last_n;
   logic [7:0] timer, timer_n;
   logic acc_n, dis_n, to_n, req_own, busy_n;
   logic [CNT_W-1:0] credit0_n, credit1_n;
   assign req_own = owner ? req1 : req0;
   always_comb begin
      state_n = state;
      owner_n = owner;
      last_n  = last;
      timer_n = timer;
      acc_n   = 1'b0;
      dis_n   = 1'b0;
      to_n    = 1'b0;
      case (state)
         IDLE:
            if (req0 | req1) begin
               // on a tie the station not served last wins
               owner_n = (req0 & req1) ? ~last : req1;
               state_n = GRANT;
            end
         GRANT: begin
            state_n = CLASSIFY;
            timer_n = 8'd0;
         end
         CLASSIFY:
            if (cqs & ~cqn) begin
               acc_n   = 1'b1;
               state_n = RELEASE;
               last_n  = owner;
            end else if (cqn & ~cqs) begin
               dis_n   = 1'b1;
               state_n = RELEASE;
               last_n  = owner;
            end else if (timer == 8'(TIMEOUT - 1)) begin
               to_n    = 1'b1;
               state_n = RELEASE;
               last_n  = owner;
            end else begin
               timer_n = timer + 8'd1;
            end
         RELEASE:
            if (!req_own) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   assign busy_n = (state_n == GRANT) || (state_n == CLASSIFY);
   // increment and spend together cancel; increment saturates, spend floors at zero
   always_comb begin
      credit0_n = credit0;
      credit1_n = credit1;
      if (acc_n & ~owner & ~spend0) credit0_n = (&credit0) ? credit0 : credit0 + CNT_W'(1);
      else if (spend0 & ~(acc_n & ~owner)) credit0_n = (credit0 == '0) ? credit0 : credit0 - CNT_W'(1);
      if (acc_n & owner & ~spend1) credit1_n = (&credit1) ? credit1 : credit1 + CNT_W'(1);
      else if (spend1 & ~(acc_n & owner)) credit1_n = (credit1 == '0) ? credit1 : credit1 - CNT_W'(1);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last        <= 1'b1;
         timer       <= 8'd0;
         grant0      <= 1'b0;
         grant1      <= 1'b0;
         done        <= 1'b0;
         accept      <= 1'b0;
         discard     <= 1'b0;
         timeout_err <= 1'b0;
         credit0     <= '0;
         credit1     <= '0;
      end else begin
         state       <= state_n;
         owner       <= owner_n;
         last        <= last_n;
         timer       <= timer_n;
         grant0      <= busy_n & ~owner_n;
         grant1      <= busy_n & owner_n;
         done        <= state_n == RELEASE;
         accept      <= acc_n;
         discard     <= dis_n;
         timeout_err <= to_n;
         credit0     <= credit0_n;
         credit1     <= credit1_n;
      end
   end
endmodule

// File: tb/tb_triagem_arbiter.sv
// tb_triagem_arbiter: directed stimulus against a transaction-level model of triagem_arbiter
module tb_triagem_arbiter;
   localparam int CW = 2;
   localparam int TO = 4;
   localparam int MAXC = 3;
   logic clk = 0, reset = 0;
   logic req0 = 0, req1 = 0, spend0 = 0, spend1 = 0, cqs = 0, cqn = 0;
   logic grant0, grant1, done, accept, discard, timeout_err;
   logic [CW-1:0] credit0, credit1;
   int checks = 0, errors = 0;
   triagem_arbiter #(.CNT_W(CW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .spend0(spend0), .spend1(spend1),
      .cqs(cqs), .cqn(cqn), .grant0(grant0), .grant1(grant1), .done(done), .accept(accept),
      .discard(discard), .timeout_err(timeout_err), .credit0(credit0), .credit1(credit1));
   always #5 clk = ~clk;
   // model: m_own is the served station (-1 when nobody), m_age counts edges since the grant edge,
   // m_res marks that the verdict is in and the station is being released
   int m_own, m_age, m_cr0, m_cr1;
   bit m_res, m_lst, m_acc, m_dis, m_to;
   logic acc_now;
   assign acc_now = m_own >= 0 && !m_res && m_age >= 1 && cqs && !cqn;
   function automatic int next_cr(input int c, input bit inc, input bit sp);
      if (inc && !sp) return c < MAXC ? c + 1 : c;
      if (sp && !inc) return c > 0 ? c - 1 : c;
      return c;
   endfunction
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_own <= -1; m_age <= 0; m_res <= 0; m_lst <= 1;
         m_cr0 <= 0; m_cr1 <= 0; m_acc <= 0; m_dis <= 0; m_to <= 0;
      end else begin
         m_acc <= 0; m_dis <= 0; m_to <= 0;
         m_cr0 <= next_cr(m_cr0, acc_now && m_own == 0, spend0);
         m_cr1 <= next_cr(m_cr1, acc_now && m_own == 1, spend1);
         if (m_own < 0) begin
            if (req0 || req1) begin
               m_own <= (req0 && req1) ? (m_lst ? 0 : 1) : (req0 ? 0 : 1);
               m_age <= 0;
               m_res <= 0;
            end
         end else if (!m_res) begin
            m_age <= m_age + 1;
            if (m_age >= 1) begin
               if (cqs && !cqn) begin m_res <= 1; m_acc <= 1; m_lst <= m_own[0]; end
               else if (cqn && !cqs) begin m_res <= 1; m_dis <= 1; m_lst <= m_own[0]; end
               else if (m_age == TO) begin m_res <= 1; m_to <= 1; m_lst <= m_own[0]; end
            end
         end else if (!(m_own == 1 ? req1 : req0)) m_own <= -1;
      end
   end
   task automatic chk(input string n, input int a, input int e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask
   always @(negedge clk) if (!reset) begin
      chk("grant0", grant0, int'(m_own == 0 && !m_res));
      chk("grant1", grant1, int'(m_own == 1 && !m_res));
      chk("done", done, int'(m_own >= 0 && m_res));
      chk("accept", accept, m_acc);
      chk("discard", discard, m_dis);
      chk("timeout_err", timeout_err, m_to);
      chk("credit0", credit0, m_cr0);
      chk("credit1", credit1, m_cr1);
   end
   task automatic step();
      @(negedge clk);
      #1;
   endtask
   task automatic do_reset();
      reset = 1;
      step();
      reset = 0;
   endtask
   task automatic wait_grant(output int who);
      int i = 0;
      while (!(grant0 || grant1) && i < 20) begin step(); i++; end
      chk("grant seen", int'(grant0 || grant1), 1);
      who = grant1 ? 1 : 0;
   endtask
   task automatic wait_done(input string n);
      int i = 0;
      while (!done && i < 20) begin step(); i++; end
      chk(n, done, 1);
   endtask
   task automatic acc_txn(input bit s, input bit sp);
      if (s) req1 = 1; else req0 = 1;
      cqs = 1; cqn = 0;
      step(); step();
      if (s) spend1 = sp; else spend0 = sp;
      step();
      spend0 = 0; spend1 = 0;
      chk("acc pulse", accept, 1);
      req0 = 0; req1 = 0;
      step();
   endtask
   int exp_ord[3] = '{0, 1, 0};
   int w;
   initial begin
      #1 reset = 1;
      step(); step();
      reset = 0;
      chk("rst credit0", credit0, 0);
      chk("rst grant0", grant0, 0);
      chk("rst done", done, 0);
      // round-robin tie from reset
      cqs = 1; cqn = 0; req0 = 1; req1 = 1;
      for (int i = 0; i < 3; i++) begin
         wait_grant(w);
         chk("rr order", w, exp_ord[i]);
         wait_done("rr done");
         if (w == 1) req1 = 0; else req0 = 0;
         step();
         if (i < 2) begin if (w == 1) req1 = 1; else req0 = 1; end
      end
      wait_grant(w);
      chk("rr 4th", w, 1);
      req1 = 0;
      repeat (4) step();
      chk("rr credit0", credit0, 2);
      chk("rr credit1", credit1, 2);
      chk("rr idle", done, 0);
      // single accept with exact latency
      do_reset();
      req0 = 1; cqs = 1; cqn = 0;
      step(); chk("sa grant k", grant0, 1);
      step(); chk("sa grant k+1", grant0, 1); chk("sa no early acc", accept, 0);
      step(); chk("sa accept", accept, 1); chk("sa credit0", credit0, 1); chk("sa done", done, 1);
      step(); chk("sa done hold", done, 1); chk("sa acc once", accept, 0);
      req0 = 0;
      step(); chk("sa done drop", done, 0);
      // spend at zero
      spend1 = 1; step(); spend1 = 0;
      chk("spend at 0", credit1, 0);
      // invalid codes then discard on the last timer cycle
      req1 = 1; cqs = 1; cqn = 1;
      repeat (5) step();
      chk("dc unresolved", done, 0);
      cqs = 0;
      step();
      chk("dc discard", discard, 1); chk("dc no timeout", timeout_err, 0); chk("dc credit1", credit1, 0);
      req1 = 0; cqn = 0;
      step(); chk("dc idle", done, 0);
      // timeout
      req1 = 1;
      repeat (5) step();
      chk("to early", timeout_err, 0); chk("to grant1", grant1, 1);
      step();
      chk("to pulse", timeout_err, 1); chk("to done", done, 1); chk("to credit1", credit1, 0);
      req1 = 0;
      step(); chk("to idle", done, 0); chk("to grant off", grant1, 0);
      // credit saturation and coincident spend
      acc_txn(0, 0); acc_txn(0, 0);
      chk("cr 3", credit0, 3);
      acc_txn(0, 0);
      chk("cr sat", credit0, 3);
      acc_txn(0, 1);
      chk("cr sat+spend", credit0, 3);
      spend0 = 1; step(); spend0 = 0;
      chk("cr spend", credit0, 2);
      acc_txn(0, 1);
      chk("cr inc+spend", credit0, 2);
      // reset mid-CLASSIFY
      req0 = 1; cqs = 0; cqn = 0;
      step(); step();
      chk("mr classify", grant0, 1);
      reset = 1;
      #1;
      chk("mr credit0", credit0, 0); chk("mr grant0", grant0, 0); chk("mr done", done, 0);
      step();
      reset = 0;
      req1 = 1; cqs = 1;
      wait_grant(w);
      chk("mr tie", w, 0);
      wait_done("mr done");
      req0 = 0; req1 = 0;
      step(); step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
